// File: rtl/present_pkg.sv
// present_pkg: shared PRESENT S-box constants and the S-box layer FSM state type.
// Contents: NIBBLES, SBOX/SBOX_INV 16x4 tables, slayer_state_t {IDLE,BUSY,DONE}.
package present_pkg;
  localparam int NIBBLES = 16;
  localparam logic [3:0] SBOX [NIBBLES] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };
  localparam logic [3:0] SBOX_INV [NIBBLES] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };
  typedef enum logic [1:0] {IDLE, BUSY, DONE} slayer_state_t;
endpackage

// File: rtl/present_sbox4.sv
// present_sbox4: combinational 4-bit PRESENT S-box (forward, or inverse when built with SLAYER_INV_EN).
// Ports: nib (in, 4) nibble to substitute; inv (in, 1, only with SLAYER_INV_EN) inverse select;
//        sub (out, 4) substituted nibble.
module present_sbox4
  import present_pkg::*;
(
  input  logic [3:0] nib,
`ifdef SLAYER_INV_EN
  input  logic       inv,
`endif
  output logic [3:0] sub
);
`ifdef SLAYER_INV_EN
  assign sub = inv ? SBOX_INV[nib] : SBOX[nib];
`else
  assign sub = SBOX[nib];
`endif
endmodule

// File: rtl/present_slayer_serial.sv
// present_slayer_serial: nibble-serial PRESENT S-box layer, NIB_PER_CYC nibbles per cycle.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data accept one 64-bit state;
//        inv_i (only with SLAYER_INV_EN) selects the inverse S-box, latched at accept;
//        out_valid/out_ready/out_data present the substituted state.
// Optional feature macro: SLAYER_INV_EN.
module present_slayer_serial
  import present_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int NIB_PER_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef SLAYER_INV_EN
  input  logic              inv_i,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);
  localparam int STEPS = NIBBLES / NIB_PER_CYC;
  localparam int SW    = 4 * NIB_PER_CYC;
  localparam int CW    = STEPS > 1 ? $clog2(STEPS) : 1;
  if (DATA_W != 64) begin : g_bad_width
    $error("present_slayer_serial: DATA_W must be 64");
  end
  if (NIB_PER_CYC != 1 && NIB_PER_CYC != 2 && NIB_PER_CYC != 4 &&
      NIB_PER_CYC != 8 && NIB_PER_CYC != 16) begin : g_bad_npc
    $error("present_slayer_serial: NIB_PER_CYC must be 1, 2, 4, 8 or 16");
  end
  slayer_state_t     state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] nxt;
  logic [SW-1:0]     sub;
`ifdef SLAYER_INV_EN
  logic              inv_q;
`endif
  for (genvar i = 0; i < NIB_PER_CYC; i++) begin : g_sbox
    present_sbox4 u_sbox (
      .nib (data[4*i +: 4]),
`ifdef SLAYER_INV_EN
      .inv (inv_q),
`endif
      .sub (sub[4*i +: 4])
    );
  end
  // substituted low nibbles wrap to the top, so after STEPS steps the order is restored
  if (SW == DATA_W) begin : g_full
    assign nxt = sub;
  end else begin : g_rot
    assign nxt = {sub, data[DATA_W-1:SW]};
  end
  assign out_data = data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      data      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
`ifdef SLAYER_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data     <= in_data;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
`ifdef SLAYER_INV_EN
            inv_q    <= inv_i;
`endif
          end else begin
            in_ready <= 1'b1;
          end
        end
        BUSY: begin
          data <= nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(STEPS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_present_slayer_serial.sv
// tb_present_slayer_serial: self-checking bench for present_slayer_serial at NIB_PER_CYC = 1, 4, 16.
module tb_present_slayer_serial;
  typedef struct {
    logic [63:0] din;
    logic [63:0] dout;
  } vec_t;
  logic        clk;
  logic        rst_n;
  logic [2:0]  iv, ir, ov, ordy;
  logic [63:0] id [3];
  logic [63:0] od [3];
`ifdef SLAYER_INV_EN
  logic [2:0]  inv;
`endif
  int vec = 0;
  int err = 0;
  int steps [3] = '{16, 4, 1};
  present_slayer_serial #(.DATA_W(64), .NIB_PER_CYC(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
`ifdef SLAYER_INV_EN
    .inv_i(inv[0]),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]));
  present_slayer_serial #(.DATA_W(64), .NIB_PER_CYC(4)) u_n4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
`ifdef SLAYER_INV_EN
    .inv_i(inv[1]),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]));
  present_slayer_serial #(.DATA_W(64), .NIB_PER_CYC(16)) u_n16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
`ifdef SLAYER_INV_EN
    .inv_i(inv[2]),
`endif
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // S-box listed in index order 0..F, index 0 in the top nibble
  function automatic logic [3:0] sf(logic [3:0] n);
    logic [63:0] t;
    t = 64'hC56B90AD3EF84712;
    return t[63 - 4*int'(n) -: 4];
  endfunction
  function automatic logic [63:0] slayer(logic [63:0] x);
    logic [63:0] r;
    for (int k = 0; k < 16; k++) r[4*k +: 4] = sf(x[4*k +: 4]);
    return r;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(int u);
    int n = 0;
    while (!ir[u] && n < 100) begin
      tick();
      n++;
    end
    if (!ir[u]) chk("wait_in_ready", {63'd0, ir[u]}, 64'd1);
  endtask
  task automatic wait_ov(int u, output int lat);
    lat = 0;
    while (!ov[u] && lat < 100) begin
      tick();
      lat++;
    end
    if (!ov[u]) chk("wait_out_valid", {63'd0, ov[u]}, 64'd1);
  endtask
  task automatic run(int u, logic [63:0] din, logic inv_v, output logic [63:0] got, output int lat);
    wait_ready(u);
    iv[u] = 1'b1;
    id[u] = din;
`ifdef SLAYER_INV_EN
    inv[u] = inv_v;
`else
    if (inv_v) $display("note: inverse request ignored in forward-only build");
`endif
    tick();
    iv[u] = 1'b0;
    wait_ov(u, lat);
    got = od[u];
    ordy[u] = 1'b1;
    tick();
    ordy[u] = 1'b0;
  endtask
  task automatic stream(int u, int n);
    logic [63:0] src [$];
    logic [63:0] q [$];
    int sent = 0, got = 0, cyc = 0;
    int limit = n * (steps[u] + 2) * 4 + 200;
    logic acc, dlv;
    logic [63:0] dv;
    for (int i = 0; i < n; i++) src.push_back({$urandom, $urandom});
    while (got < n && cyc < limit) begin
      iv[u] = sent < n;
      id[u] = sent < n ? src[sent] : {$urandom, $urandom};
      ordy[u] = 1'($urandom_range(1, 0));
      acc = iv[u] & ir[u];
      dlv = ov[u] & ordy[u];
      dv = od[u];
      tick();
      cyc++;
      if (acc) begin
        q.push_back(slayer(src[sent]));
        sent++;
      end
      if (dlv) begin
        if (q.size() == 0) chk("stream_dup", 64'd1, 64'd0);
        else chk("stream_data", dv, q.pop_front());
        got++;
      end
    end
    iv[u] = 1'b0;
    ordy[u] = 1'b0;
    chk("stream_count", 64'(got), 64'(n));
    repeat (steps[u] + 4) tick();
    chk("stream_extra_valid", {63'd0, ov[u]}, 64'd0);
  endtask
  vec_t tbl [4];
  logic [63:0] got, held;
  int lat;
  initial begin
    tbl[0] = '{64'h0000000000000000, 64'hCCCCCCCCCCCCCCCC};
    tbl[1] = '{64'h0123456789ABCDEF, 64'hC56B90AD3EF84712};
    tbl[2] = '{64'hFEDCBA9876543210, 64'h21748FE3DA09B65C};
    tbl[3] = '{64'h1111111111111111, 64'h5555555555555555};
    rst_n = 1'b0;
    iv = '0;
    ordy = '0;
`ifdef SLAYER_INV_EN
    inv = '0;
`endif
    for (int u = 0; u < 3; u++) id[u] = '0;
    #12;
    for (int u = 0; u < 3; u++) begin
      chk("reset_in_ready", {63'd0, ir[u]}, 64'd0);
      chk("reset_out_valid", {63'd0, ov[u]}, 64'd0);
      chk("reset_out_data", od[u], 64'd0);
    end
    #5 rst_n = 1'b1;
    tick();
    tick();
    for (int u = 0; u < 3; u++) chk("idle_in_ready", {63'd0, ir[u]}, 64'd1);
    for (int u = 0; u < 3; u++)
      for (int i = 0; i < 4; i++) begin
        run(u, tbl[i].din, 1'b0, got, lat);
        chk("table_data", got, tbl[i].dout);
        chk("table_latency", 64'(lat), 64'(steps[u]));
      end
    wait_ready(0);
    iv[0] = 1'b1;
    id[0] = 64'h0123456789ABCDEF;
    tick();
    iv[0] = 1'b0;
    wait_ov(0, lat);
    held = od[0];
    chk("hold_first", held, 64'hC56B90AD3EF84712);
    for (int i = 0; i < 10; i++) begin
      iv[0] = 1'($urandom_range(1, 0));
      id[0] = {$urandom, $urandom};
      tick();
      chk("hold_data", od[0], held);
      chk("hold_valid", {63'd0, ov[0]}, 64'd1);
      chk("hold_in_ready", {63'd0, ir[0]}, 64'd0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    chk("release_valid", {63'd0, ov[0]}, 64'd0);
    chk("release_in_ready", {63'd0, ir[0]}, 64'd1);
    repeat (20) tick();
    chk("no_second_accept", {63'd0, ov[0]}, 64'd0);
    run(0, 64'hFEDCBA9876543210, 1'b0, got, lat);
    chk("after_hold", got, 64'h21748FE3DA09B65C);
    wait_ready(0);
    iv[0] = 1'b1;
    id[0] = 64'h0123456789ABCDEF;
    tick();
    iv[0] = 1'b0;
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_valid", {63'd0, ov[0]}, 64'd0);
    chk("midreset_data", od[0], 64'd0);
    chk("midreset_in_ready", {63'd0, ir[0]}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("postreset_in_ready", {63'd0, ir[0]}, 64'd1);
    run(0, 64'h0123456789ABCDEF, 1'b0, got, lat);
    chk("postreset_data", got, 64'hC56B90AD3EF84712);
    chk("postreset_latency", 64'(lat), 64'd16);
`ifdef SLAYER_INV_EN
    for (int u = 0; u < 3; u++) begin
      run(u, 64'hC56B90AD3EF84712, 1'b1, got, lat);
      chk("inverse_data", got, 64'h0123456789ABCDEF);
    end
    wait_ready(0);
    iv[0] = 1'b1;
    inv[0] = 1'b1;
    id[0] = 64'h21748FE3DA09B65C;
    tick();
    iv[0] = 1'b0;
    repeat (3) tick();
    inv[0] = 1'b0;
    wait_ov(0, lat);
    chk("inverse_midbusy", od[0], 64'hFEDCBA9876543210);
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
`endif
    for (int u = 0; u < 3; u++) stream(u, 20);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
